mod_n_updown_counter: RTL and testbench



---
 rtl/mod_n_updown_counter.sv | 81 ++++++++
 tb/tb_mod_n_updown_counter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mod_n_updown_counter.sv
// WIDTH-bit modulo counter with runtime-programmable modulus, up/down count,
// parallel load, one-shot halt mode and a combinational cascade terminal count.
module mod_n_updown_counter #(
  parameter int WIDTH = 3,
  parameter int N     = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             set_mod,
  input  logic [WIDTH:0]   mod_in,
  input  logic             one_shot,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH:0]   RESET_MOD = (WIDTH+1)'(N);
  localparam logic [WIDTH:0]   MAX_MOD   = (WIDTH+1)'(1) << WIDTH;
  localparam logic [WIDTH:0]   ONE_EXT   = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO      = '0;

  logic [WIDTH:0] mod_reg;
  logic [WIDTH:0] mod_m1;
  logic [WIDTH:0] q_ext;
  logic           at_term;
  logic           mod_ok;
  logic           load_ok;

  // Terminal compare is done one bit wider so a modulus of 2**WIDTH fits.
  assign mod_m1  = mod_reg - ONE_EXT;
  assign q_ext   = {1'b0, Q};
  assign at_term = up ? (q_ext == mod_m1) : (Q == ZERO);
  assign tc      = en & ~done & at_term;
  assign mod_ok  = (mod_in != '0) && (mod_in <= MAX_MOD);
  assign load_ok = ({1'b0, load_val} < mod_reg);

  always_ff @(posedge clk) begin
    if (clr) begin
      Q       <= ZERO;
      mod_reg <= RESET_MOD;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      if (set_mod) begin
        // A rejected modulus also swallows any load requested alongside it.
        if (mod_ok) begin
          mod_reg <= mod_in;
          Q       <= ZERO;
          done    <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end else if (load) begin
        if (load_ok) begin
          Q    <= load_val;
          done <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end else if (en && !done) begin
        if (at_term) begin
          if (one_shot) begin
            done <= 1'b1;
          end else begin
            Q <= up ? ZERO : mod_m1[WIDTH-1:0];
          end
        end else begin
          Q <= up ? (Q + ONE) : (Q - ONE);
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Scoreboard bench: a behavioural model predicts Q/done/err per edge and tc
// per cycle; predictions are queued at drive time and popped after the edge.
module tb_mod_n_updown_counter;

  logic       clk;
  logic       clr;
  logic       en;
  logic       up;
  logic       load;
  logic [2:0] load_val;
  logic       set_mod;
  logic [3:0] mod_in;
  logic       one_shot;
  logic [2:0] q;
  logic       tc;
  logic       done;
  logic       err;

  int compare_count  = 0;
  int mismatch_count = 0;

  int m_q    = 0;
  int m_mod  = 3;
  int m_done = 0;
  int m_err  = 0;

  typedef struct {
    int q;
    int done;
    int err;
  } exp_t;

  exp_t sb[$];

  mod_n_updown_counter #(.WIDTH(3), .N(3)) dut (
    .clk      (clk),
    .clr      (clr),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .set_mod  (set_mod),
    .mod_in   (mod_in),
    .one_shot (one_shot),
    .Q        (q),
    .tc       (tc),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // One clock cycle: drive, check tc, predict the edge, then compare after it.
  task automatic applyStimulus(input bit c, input bit e, input bit u, input bit ld,
                               input int lv, input bit sm, input int mi, input bit os,
                               input string tag);
    int   exp_tc;
    exp_t pred;
    exp_t got;
    @(negedge clk);
    clr      = c;
    en       = e;
    up       = u;
    load     = ld;
    load_val = 3'(lv);
    set_mod  = sm;
    mod_in   = 4'(mi);
    one_shot = os;
    #1;
    exp_tc = (e && m_done == 0 && (u ? (m_q == m_mod - 1) : (m_q == 0))) ? 1 : 0;
    checkOutput({tag, ".tc"}, int'(tc), exp_tc);

    if (c) begin
      m_q = 0; m_mod = 3; m_done = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (sm) begin
        if (mi >= 1 && mi <= 8) begin
          m_mod = mi; m_q = 0; m_done = 0;
        end else begin
          m_err = 1;
        end
      end else if (ld) begin
        if (lv < m_mod) begin
          m_q = lv; m_done = 0;
        end else begin
          m_err = 1;
        end
      end else if (e && m_done == 0) begin
        if (exp_tc == 1) begin
          if (os) m_done = 1;
          else    m_q = u ? 0 : m_mod - 1;
        end else begin
          m_q = u ? m_q + 1 : m_q - 1;
        end
      end
    end
    pred.q = m_q; pred.done = m_done; pred.err = m_err;
    sb.push_back(pred);

    @(posedge clk);
    #1;
    got = sb.pop_front();
    checkOutput({tag, ".Q"},    int'(q),    got.q);
    checkOutput({tag, ".done"}, int'(done), got.done);
    checkOutput({tag, ".err"},  int'(err),  got.err);
  endtask

  task automatic count_cycles(input int n, input bit u, input bit os, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(0, 1, u, 0, 0, 0, 0, os, tag);
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    set_mod = 1'b0; mod_in = '0; one_shot = 1'b0;

    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, "reset");
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, "idle");
    checkOutput("reset_q_const", int'(q), 0);

    count_cycles(8, 1, 0, "up_mod3");
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, "clr2");
    count_cycles(4, 0, 0, "down_mod3");

    applyStimulus(0, 0, 1, 0, 0, 1, 8, 0, "setmod8");
    count_cycles(9, 1, 0, "up_mod8");
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0, "setmod0_bad");
    applyStimulus(0, 0, 1, 0, 0, 1, 9, 0, "setmod9_bad");
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, "err_clears");
    count_cycles(3, 0, 0, "down_mod8");

    applyStimulus(0, 0, 1, 0, 0, 1, 3, 0, "setmod3");
    count_cycles(5, 1, 1, "oneshot");
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, "done_holds");
    checkOutput("done_tc_low", int'(tc), 0);
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 0, "load1_clears_done");

    applyStimulus(0, 0, 1, 1, 5, 0, 0, 0, "load5_bad");
    applyStimulus(0, 0, 1, 1, 2, 1, 5, 0, "load_vs_setmod5");
    count_cycles(6, 1, 0, "up_mod5");
    applyStimulus(0, 0, 1, 1, 2, 1, 12, 0, "load_vs_badsetmod");

    applyStimulus(0, 0, 1, 0, 0, 1, 6, 0, "setmod6");
    applyStimulus(0, 0, 1, 1, 4, 0, 0, 0, "load4");
    applyStimulus(1, 1, 1, 1, 2, 1, 7, 0, "clr_wins");
    count_cycles(4, 1, 0, "after_clr");

    applyStimulus(0, 0, 1, 0, 0, 1, 1, 0, "setmod1");
    count_cycles(3, 1, 0, "mod1_up");
    count_cycles(2, 0, 0, "mod1_down");
    count_cycles(2, 0, 1, "mod1_oneshot");

    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 1), ($urandom_range(0, 9) == 0),
                    $urandom_range(0, 7), ($urandom_range(0, 14) == 0),
                    $urandom_range(0, 15), ($urandom_range(0, 3) == 0), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
